// File: rtl/ins_fetch_pkg.sv
// rtl/ins_fetch_pkg.sv - shared widths, PC step and fetch buffer entry type
package ins_fetch_pkg;

    localparam int DEF_ADDR_W  = 64;
    localparam int DEF_INSTR_W = 32;
    localparam int PC_STEP     = 4;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ins_fetch_fifo.sv
// rtl/ins_fetch_fifo.sv - in-order fetch buffer with flush; head reads zero when empty
module ins_fetch_fifo
    import ins_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign count = count_q;
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Stored words are never exposed unless the slot holds a live entry.
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ins_fetch.sv
// rtl/ins_fetch.sv - PC owner and fetch requester feeding decode through a small buffer
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                INSTR_W   = DEF_INSTR_W,
    parameter int                DEPTH     = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [ADDR_W-1:0] MEM_BYTES = 'd128
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_q,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               fetch_fault
);

    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic                   fault_q, fault_d;
    logic                   oob, pop, space, push, empty;
    logic [$clog2(DEPTH):0] count;
    fetch_entry_t           push_data, head_data;

    assign mem_addr    = pc_q;
    assign fetch_fault = fault_q;
    assign oob         = (pc_q >= MEM_BYTES);
    assign out_valid   = ~empty;
    assign pop         = out_valid & out_ready;
    // A pop frees a slot in the same cycle, so a full buffer still streams.
    assign space       = (count < ($clog2(DEPTH)+1)'(DEPTH)) | pop;
    assign push        = space & ~redirect_valid & ~oob;

    assign push_data.pc    = pc_q;
    assign push_data.instr = mem_q;
    assign out_pc          = head_data.pc;
    assign out_instr       = head_data.instr;

    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
            fault_d = 1'b0;
        end else begin
            if (push) pc_d = pc_q + ADDR_W'(PC_STEP);
            if (oob)  fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    ins_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head_data),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: tb/tb_ins_fetch.sv
// tb/tb_ins_fetch.sv - directed bench for ins_fetch with a combinational insMem model
module tb_ins_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] mem_addr;
    logic [31:0] mem_q;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_fault;

    logic [31:0] rom [32];
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign mem_q = (mem_addr < 64'd128) ? rom[mem_addr[6:2]] : 32'hDEAD_BEEF;

    ins_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_q          (mem_q),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_head(input string tag, input logic [63:0] pc);
        check({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, ".pc"}, out_pc, pc);
        check({tag, ".instr"}, {32'd0, out_instr}, {32'd0, rom[pc[6:2]]});
    endtask

    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst_n = 1'b0;
        out_ready = ready;
        redirect_valid = 1'b0;
        #1;
        check("rst.valid", {63'd0, out_valid}, 64'd0);
        check("rst.addr", mem_addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 + i;
        rom[0] = 32'h0005_2A03;
        rom[1] = 32'h0140_0AB3;
        rom[3] = 32'h00AA_2423;
        rst_n = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (2) @(negedge clk);
        check("reset.valid", {63'd0, out_valid}, 64'd0);
        check("reset.pc", out_pc, 64'd0);
        check("reset.instr", {32'd0, out_instr}, 64'd0);
        check("reset.fault", {63'd0, fetch_fault}, 64'd0);
        check("reset.addr", mem_addr, 64'd0);
        rst_n = 1'b1;

        // Back-to-back streaming from reset
        step();
        check("c1.instr_lit", {32'd0, out_instr}, 64'h0005_2A03);
        check_head("c1", 64'd0);
        step();
        check("c2.instr_lit", {32'd0, out_instr}, 64'h0140_0AB3);
        check_head("c2", 64'd4);
        for (int k = 3; k <= 5; k++) begin
            step();
            check_head("stream", 64'(4 * (k - 1)));
        end

        // Stall with full buffer, then drain in order
        do_reset(1'b0);
        step();
        check_head("stall1", 64'd0);
        check("stall1.addr", mem_addr, 64'd4);
        step();
        check("stall2.addr", mem_addr, 64'd8);
        step();
        check("stall3.addr", mem_addr, 64'd8);
        check_head("stall3", 64'd0);
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_head("drain", 64'(4 * k));
        end

        // Redirect with a full buffer
        do_reset(1'b0);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 64'h0F;
        step();
        redirect_valid = 1'b0;
        check("redir.valid", {63'd0, out_valid}, 64'd0);
        check("redir.addr", mem_addr, 64'h0C);
        step();
        check("redir.instr_lit", {32'd0, out_instr}, 64'h00AA_2423);
        check_head("redir", 64'h0C);

        // Sweep to the end of memory and fault
        do_reset(1'b1);
        for (int k = 1; k <= 32; k++) begin
            step();
            check_head("sweep", 64'(4 * (k - 1)));
        end
        check("sweep.addr", mem_addr, 64'd128);
        check("sweep.fault_pre", {63'd0, fetch_fault}, 64'd0);
        step();
        check("fault.set", {63'd0, fetch_fault}, 64'd1);
        check("fault.empty", {63'd0, out_valid}, 64'd0);
        step();
        check("fault.hold", {63'd0, fetch_fault}, 64'd1);
        check("fault.addr", mem_addr, 64'd128);
        redirect_valid = 1'b1;
        redirect_pc = 64'd0;
        step();
        redirect_valid = 1'b0;
        check("fault.clear", {63'd0, fetch_fault}, 64'd0);
        check("fault.raddr", mem_addr, 64'd0);
        step();
        check_head("resume", 64'd0);

        // Redirect coinciding with a pop and a push opportunity
        step();
        step();
        check_head("rp.pre", 64'd8);
        check("rp.addr_pre", mem_addr, 64'd12);
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        step();
        redirect_valid = 1'b0;
        check("rp.valid", {63'd0, out_valid}, 64'd0);
        check("rp.addr", mem_addr, 64'h40);
        step();
        check_head("rp.post", 64'h40);

        // Asynchronous reset pulse mid-stream
        step();
        rst_n = 1'b0;
        #1;
        check("arst.valid", {63'd0, out_valid}, 64'd0);
        check("arst.addr", mem_addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_head("arst.restart", 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
